// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - single-bus 32-bit CPU datapath: register file, bus mux, ALU, Z/MAR/MDR.
// mar_out carries the memory address register to the memory side.
module cpu_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             R0in,  input logic R1in,  input logic R2in,  input logic R3in,
  input  logic             R4in,  input logic R5in,  input logic R6in,  input logic R7in,
  input  logic             R8in,  input logic R9in,  input logic R10in, input logic R11in,
  input  logic             R12in, input logic R13in, input logic R14in, input logic R15in,
  input  logic             PCin,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             Yin,
  input  logic             Zin,
  input  logic             incPC,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic             read,
  input  logic             InPortIn,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             R0out,  input logic R1out,  input logic R2out,  input logic R3out,
  input  logic             R4out,  input logic R5out,  input logic R6out,  input logic R7out,
  input  logic             R8out,  input logic R9out,  input logic R10out, input logic R11out,
  input  logic             R12out, input logic R13out, input logic R14out, input logic R15out,
  input  logic             PCout,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             ZHighOut,
  input  logic             ZLowOut,
  input  logic             MDRout,
  input  logic             InPortOut,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] mar_out
);
  localparam int SHW = $clog2(WIDTH);

  logic [15:0]          r_in, r_out;
  logic [WIDTH-1:0]     r_q [16];
  logic [WIDTH-1:0]     r_d [16];
  logic [WIDTH-1:0]     pc_q, pc_d, hi_q, hi_d, lo_q, lo_d, y_q, y_d;
  logic [WIDTH-1:0]     mar_q, mar_d, mdr_q, mdr_d, inport_q, inport_d;
  logic [2*WIDTH-1:0]   z_q, z_d;
  logic [WIDTH-1:0]     bus;
  logic [2*WIDTH-1:0]   alu_res, rot, prod;
  logic [WIDTH-1:0]     quo, rem;
  logic [SHW-1:0]       sh;

  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  // Descending scan so the lowest-numbered selected register wins.
  always_comb begin
    bus = '0;
    if (|r_out) begin
      for (int i = 15; i >= 0; i--) begin
        if (r_out[i]) bus = r_q[i];
      end
    end else if (HIout)     bus = hi_q;
    else if (LOout)         bus = lo_q;
    else if (ZHighOut)      bus = z_q[2*WIDTH-1:WIDTH];
    else if (ZLowOut)       bus = z_q[WIDTH-1:0];
    else if (PCout)         bus = pc_q;
    else if (MDRout)        bus = mdr_q;
    else if (InPortOut)     bus = inport_q;
  end

  assign bus_out = bus;
  assign mar_out = mar_q;

  always_comb begin
    sh   = bus[SHW-1:0];
    rot  = {y_q, y_q};
    prod = $signed({{WIDTH{y_q[WIDTH-1]}}, y_q}) * $signed({{WIDTH{bus[WIDTH-1]}}, bus});
    quo  = '0;
    rem  = '0;
    if (bus != '0) begin
      quo = $signed(y_q) / $signed(bus);
      rem = $signed(y_q) % $signed(bus);
    end
    alu_res = '0;
    case (opcode)
      5'b00011, 5'b01100: alu_res[WIDTH-1:0] = y_q + bus;
      5'b00100:           alu_res[WIDTH-1:0] = y_q - bus;
      5'b00101, 5'b01101: alu_res[WIDTH-1:0] = y_q & bus;
      5'b00110, 5'b01110: alu_res[WIDTH-1:0] = y_q | bus;
      5'b00111: begin
        rot = rot >> sh;
        alu_res[WIDTH-1:0] = rot[WIDTH-1:0];
      end
      5'b01000: begin
        rot = rot << sh;
        alu_res[WIDTH-1:0] = rot[2*WIDTH-1:WIDTH];
      end
      5'b01001: alu_res[WIDTH-1:0] = y_q >> sh;
      5'b01010: alu_res[WIDTH-1:0] = $unsigned($signed(y_q) >>> sh);
      5'b01011: alu_res[WIDTH-1:0] = y_q << sh;
      5'b01111: alu_res = prod;
      5'b10000: alu_res = {rem, quo};
      5'b10001: alu_res[WIDTH-1:0] = '0 - bus;
      5'b10010: alu_res[WIDTH-1:0] = ~bus;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 16; i++) r_d[i] = r_in[i] ? bus : r_q[i];
    pc_d     = PCin ? bus : (incPC ? pc_q + 1'b1 : pc_q);
    hi_d     = HIin ? bus : hi_q;
    lo_d     = LOin ? bus : lo_q;
    y_d      = Yin ? bus : y_q;
    z_d      = Zin ? alu_res : z_q;
    mar_d    = MARin ? bus : mar_q;
    mdr_d    = MDRin ? (read ? Mdatain : bus) : mdr_q;
    inport_d = InPortIn ? Mdatain : inport_q;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      pc_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      y_q      <= '0;
      z_q      <= '0;
      mar_q    <= '0;
      mdr_q    <= '0;
      inport_q <= '0;
    end else begin
      for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
      pc_q     <= pc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      y_q      <= y_d;
      z_q      <= z_d;
      mar_q    <= mar_d;
      mdr_q    <= mdr_d;
      inport_q <= inport_d;
    end
  end
endmodule

// File: tb/tb_cpu_datapath.sv
// tb/tb_cpu_datapath.sv - directed and randomized checks of cpu_datapath against an arithmetic model.
module tb_cpu_datapath;
  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] rin, rout;
  logic        PCin, HIin, LOin, Yin, Zin, incPC, MARin, MDRin, read, InPortIn;
  logic [4:0]  opcode;
  logic [31:0] Mdatain;
  logic        PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, InPortOut;
  logic [31:0] bus_out, mar_out;
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  cpu_datapath #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .PCin(PCin), .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zin(Zin), .incPC(incPC),
    .MARin(MARin), .MDRin(MDRin), .read(read), .InPortIn(InPortIn),
    .opcode(opcode), .Mdatain(Mdatain),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .PCout(PCout), .HIout(HIout), .LOout(LOout), .ZHighOut(ZHighOut), .ZLowOut(ZLowOut),
    .MDRout(MDRout), .InPortOut(InPortOut),
    .bus_out(bus_out), .mar_out(mar_out)
  );

  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    int          n  = int'(b[4:0]);
    logic [31:0] r  = '0;
    case (op)
      5'd3, 5'd12: return {32'd0, a + b};
      5'd4:        return {32'd0, a - b};
      5'd5, 5'd13: return {32'd0, a & b};
      5'd6, 5'd14: return {32'd0, a | b};
      5'd7: begin
        for (int i = 0; i < 32; i++) r[i] = a[(i + n) % 32];
        return {32'd0, r};
      end
      5'd8: begin
        for (int i = 0; i < 32; i++) r[(i + n) % 32] = a[i];
        return {32'd0, r};
      end
      5'd9:  return {32'd0, 32'(longint'(a) / (longint'(1) << n))};
      5'd10: return {32'd0, 32'(sa >>> n)};
      5'd11: return {32'd0, 32'(longint'(a) * (longint'(1) << n))};
      5'd15: return 64'(sa * sb);
      5'd16: return (b == 0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
      5'd17: return {32'd0, 32'(-sb)};
      5'd18: return {32'd0, ~b};
      default: return 64'd0;
    endcase
  endfunction

  task automatic idle();
    rin = '0; rout = '0;
    {PCin, HIin, LOin, Yin, Zin, incPC, MARin, MDRin, read, InPortIn} = '0;
    {PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, InPortOut} = '0;
    opcode = '0; Mdatain = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Source codes: 0-15 Rn, 16 HI, 17 LO, 18 ZHigh, 19 ZLow, 20 PC, 21 MDR, 22 InPort, other none.
  task automatic rd_src(input int s, output logic [31:0] v);
    if (s < 16) rout[s] = 1'b1;
    case (s)
      16: HIout = 1'b1;
      17: LOout = 1'b1;
      18: ZHighOut = 1'b1;
      19: ZLowOut = 1'b1;
      20: PCout = 1'b1;
      21: MDRout = 1'b1;
      22: InPortOut = 1'b1;
      default: ;
    endcase
    #1;
    v = bus_out;
    idle();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic load_reg(input int n, input logic [31:0] v);
    Mdatain = v; read = 1'b1; MDRin = 1'b1;
    tick();
    MDRout = 1'b1; rin[n] = 1'b1;
    tick();
  endtask

  task automatic alu_op(input int a, input int b, input logic [4:0] op);
    rout[a] = 1'b1; Yin = 1'b1;
    tick();
    rout[b] = 1'b1; opcode = op; Zin = 1'b1;
    tick();
  endtask

  task automatic chk_z(input string tag, input logic [63:0] exp);
    logic [31:0] v;
    rd_src(19, v); chk({tag, "_lo"}, v, exp[31:0]);
    rd_src(18, v); chk({tag, "_hi"}, v, exp[63:32]);
  endtask

  task automatic run_alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    load_reg(1, a);
    load_reg(2, b);
    alu_op(1, 2, op);
    chk_z(tag, exp);
  endtask

  initial begin
    logic [31:0] v, a, b;
    logic [4:0]  op;
    idle();
    clear = 1'b0;
    @(posedge clock); #1;
    do_clear();
    for (int s = 0; s < 23; s++) begin
      rd_src(s, v);
      chk($sformatf("reset_src%0d", s), v, 32'd0);
    end
    rd_src(99, v); chk("idle_bus", v, 32'd0);
    chk("reset_mar", mar_out, 32'd0);

    // OR: R3=0x1A, R7=0x16, Z=R3|R7 -> R4
    load_reg(3, 32'h1A);
    load_reg(7, 32'h16);
    alu_op(3, 7, 5'b00110);
    ZLowOut = 1'b1; rin[4] = 1'b1;
    tick();
    rd_src(4, v);  chk("or_r4", v, 32'h1E);
    rd_src(18, v); chk("or_zhi", v, 32'h0);
    alu_op(3, 7, 5'b00011);
    ZLowOut = 1'b1; rin[4] = 1'b1;
    tick();
    rd_src(4, v);  chk("add_r4", v, 32'h30);
    alu_op(7, 3, 5'b00100);
    chk_z("sub", 64'h0000_0000_FFFF_FFFC);

    run_alu("mul", 5'b01111, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    run_alu("div", 5'b10000, 32'd7, 32'd2, 64'h0000_0001_0000_0003);
    run_alu("div0", 5'b10000, 32'd7, 32'd0, 64'd0);
    run_alu("shr", 5'b01001, 32'h8000_0001, 32'd1, 64'h4000_0000);
    run_alu("shra", 5'b01010, 32'h8000_0001, 32'd1, 64'hC000_0000);
    run_alu("rol", 5'b01000, 32'h8000_0001, 32'd1, 64'h3);
    run_alu("ror", 5'b00111, 32'h8000_0001, 32'd1, 64'hC000_0000);
    run_alu("sh0", 5'b00111, 32'h1234_5678, 32'd32, 64'h1234_5678);
    run_alu("badop", 5'b11010, 32'h5, 32'h6, 64'd0);

    // PC: load all-ones, wrap on increment, PCin beats incPC
    Mdatain = 32'hFFFF_FFFF; read = 1'b1; MDRin = 1'b1;
    tick();
    MDRout = 1'b1; PCin = 1'b1;
    tick();
    rd_src(20, v); chk("pc_load", v, 32'hFFFF_FFFF);
    incPC = 1'b1;
    tick();
    rd_src(20, v); chk("pc_wrap", v, 32'h0);
    incPC = 1'b1;
    tick();
    rd_src(20, v); chk("pc_inc", v, 32'h1);
    load_reg(9, 32'h0000_1234);
    rout[9] = 1'b1; PCin = 1'b1; incPC = 1'b1;
    tick();
    rd_src(20, v); chk("pc_pri", v, 32'h0000_1234);

    // HI/LO/MAR/InPort and MDR loaded from bus
    rout[9] = 1'b1; HIin = 1'b1; MARin = 1'b1;
    tick();
    rd_src(16, v); chk("hi", v, 32'h0000_1234);
    chk("mar", mar_out, 32'h0000_1234);
    load_reg(10, 32'hCAFE_0001);
    rout[10] = 1'b1; LOin = 1'b1; MDRin = 1'b1; read = 1'b0; Mdatain = 32'hDEAD_BEEF;
    tick();
    rd_src(17, v); chk("lo", v, 32'hCAFE_0001);
    rd_src(21, v); chk("mdr_bus", v, 32'hCAFE_0001);
    Mdatain = 32'h0BAD_F00D; InPortIn = 1'b1;
    tick();
    rd_src(22, v); chk("inport", v, 32'h0BAD_F00D);

    // Bus priority and self-load
    rout[9] = 1'b1; rout[10] = 1'b1; #1; chk("pri_r9_r10", bus_out, 32'h0000_1234); idle();
    HIout = 1'b1; ZLowOut = 1'b1; PCout = 1'b1; #1; chk("pri_hi", bus_out, 32'h0000_1234); idle();
    rout[15] = 1'b1; HIout = 1'b1; #1; chk("pri_r15_hi", bus_out, 32'h0); idle();
    rout[10] = 1'b1; rin[10] = 1'b1;
    tick();
    rd_src(10, v); chk("self_load", v, 32'hCAFE_0001);

    // Clear mid-sequence overrides a concurrent load, then the sequence carries on
    load_reg(1, 32'h5);
    rout[1] = 1'b1; Yin = 1'b1;
    tick();
    rout[1] = 1'b1; rin[2] = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    rd_src(1, v);  chk("clr_r1", v, 32'h0);
    rd_src(2, v);  chk("clr_r2", v, 32'h0);
    rd_src(20, v); chk("clr_pc", v, 32'h0);
    chk("clr_mar", mar_out, 32'h0);
    opcode = 5'b00011; Zin = 1'b1;
    tick();
    rd_src(19, v); chk("clr_y", v, 32'h0);

    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      op = 5'($urandom_range(0, 31));
      if (op == 5'd16 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      run_alu($sformatf("rand%0d_op%0d", i, op), op, a, b, model(op, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
